button_pulser: RTL and testbench



---
 rtl/button_pulser.sv | 108 ++++++++++
 tb/tb_button_pulser.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/button_pulser.sv
// button_pulser: synchronise, debounce and edge-detect two buttons into
// mutually exclusive one-cycle plus/minus pulses with optional hold-to-repeat.
module button_pulser #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    output logic plus,
    output logic minus,
    output logic up_level,
    output logic down_level
);
    typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT, HELD} state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0] raw, lvl, pulse;
    assign raw = {btn_down, btn_up};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic [1:0] sync;
        logic [CNT_W-1:0] dcnt, rcnt, rcnt_nx;
        logic lv, p;
        state_t state, state_nx;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync  <= '0;
                dcnt  <= '0;
                lv    <= 1'b0;
                rcnt  <= '0;
                state <= IDLE;
            end else begin
                sync  <= {sync[0], raw[i]};
                state <= state_nx;
                rcnt  <= rcnt_nx;
                if (sync[1] == lv) begin
                    dcnt <= '0;
                end else if (dcnt == DB_LAST) begin
                    lv   <= ~lv;
                    dcnt <= '0;
                end else if (dcnt != '1) begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end

        // A debounced fall always wins over a repeat that is due on the same edge.
        always_comb begin
            state_nx = state;
            rcnt_nx  = (rcnt == '1) ? rcnt : rcnt + 1'b1;
            p        = 1'b0;
            case (state)
                IDLE: begin
                    rcnt_nx = '0;
                    if (lv) begin
                        p        = 1'b1;
                        state_nx = (REPEAT_EN != 0) ? HOLD_DELAY : HELD;
                    end
                end
                HOLD_DELAY: begin
                    if (!lv) begin
                        state_nx = IDLE;
                    end else if (rcnt == DLY_LAST) begin
                        p        = 1'b1;
                        rcnt_nx  = '0;
                        state_nx = HOLD_REPEAT;
                    end
                end
                HOLD_REPEAT: begin
                    if (!lv) begin
                        state_nx = IDLE;
                    end else if (rcnt == PER_LAST) begin
                        p       = 1'b1;
                        rcnt_nx = '0;
                    end
                end
                default: state_nx = lv ? HELD : IDLE;
            endcase
        end

        assign lvl[i]   = lv;
        assign pulse[i] = p;
    end

    // Levels are registered alongside the pulses so they line up with them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            plus       <= 1'b0;
            minus      <= 1'b0;
            up_level   <= 1'b0;
            down_level <= 1'b0;
        end else begin
            plus       <= pulse[0] & ~lvl[1];
            minus      <= pulse[1] & ~lvl[0];
            up_level   <= lvl[0];
            down_level <= lvl[1];
        end
    end
endmodule

// File: tb/tb_button_pulser.sv
// tb_button_pulser: scoreboard bench; stimulus queues expected pulse cycles,
// a negedge monitor pops and compares whenever a pulse appears.
module tb_button_pulser;
    logic clk = 1'b0;
    logic rst_a = 1'b0, up_a = 1'b0, down_a = 1'b0;
    logic rst_b = 1'b0, up_b = 1'b0, down_b = 1'b0;
    logic plus_a, minus_a, up_level_a, down_level_a;
    logic plus_b, minus_b, up_level_b, down_level_b;
    int cyc = 0;
    int vectors = 0;
    int errs = 0;
    int q[4][$];
    bit done = 1'b0;
    string names[4] = '{"plus_a", "minus_a", "plus_b", "minus_b"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_pulser #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
                    .REPEAT_EN(0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_a), .btn_up(up_a), .btn_down(down_a),
        .plus(plus_a), .minus(minus_a), .up_level(up_level_a), .down_level(down_level_a));

    button_pulser #(.DEBOUNCE_CYCLES(2), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
                    .REPEAT_EN(1), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_b), .btn_up(up_b), .btn_down(down_b),
        .plus(plus_b), .minus(minus_b), .up_level(up_level_b), .down_level(down_level_b));

    always @(negedge clk) begin
        logic [3:0] p;
        p = {minus_b, plus_b, minus_a, plus_a};
        if (!done) begin
            for (int c = 0; c < 4; c++) begin
                while (q[c].size() > 0 && q[c][0] < cyc) begin
                    vectors++;
                    errs++;
                    $display("FAIL %s missed pulse: expected at cycle %0d, absent (now %0d)", names[c], q[c][0], cyc);
                    void'(q[c].pop_front());
                end
                if (p[c]) begin
                    vectors++;
                    if (q[c].size() == 0) begin
                        errs++;
                        $display("FAIL %s unexpected pulse at cycle %0d, none required", names[c], cyc);
                    end else if (q[c][0] != cyc) begin
                        errs++;
                        $display("FAIL %s pulse at cycle %0d, required at cycle %0d", names[c], cyc, q[c][0]);
                        void'(q[c].pop_front());
                    end else begin
                        void'(q[c].pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %b, required %b", nm, cyc, got, exp);
        end
    endtask

    initial begin
        int n;
        tick(3);
        check("rst plus_a", plus_a, 1'b0);
        check("rst up_level_a", up_level_a, 1'b0);
        check("rst down_level_a", down_level_a, 1'b0);
        check("rst plus_b", plus_b, 1'b0);
        check("rst up_level_b", up_level_b, 1'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick(2);

        // clean press, no repeat
        n = cyc;
        up_a = 1'b1;
        q[0].push_back(n + 7);
        tick(6);
        check("press up_level_a early", up_level_a, 1'b0);
        tick(1);
        check("press up_level_a", up_level_a, 1'b1);
        tick(33);
        up_a = 1'b0;
        tick(6);
        check("release up_level_a early", up_level_a, 1'b1);
        tick(1);
        check("release up_level_a", up_level_a, 1'b0);
        tick(5);

        // bounce then settle
        for (int i = 0; i < 10; i++) begin
            down_a = (i % 2 == 0);
            tick(2);
        end
        check("bounce down_level_a", down_level_a, 1'b0);
        down_a = 1'b1;
        q[1].push_back(cyc + 7);
        tick(7);
        check("settled down_level_a", down_level_a, 1'b1);
        tick(8);
        down_a = 1'b0;
        tick(10);

        // simultaneous press
        up_a = 1'b1;
        down_a = 1'b1;
        tick(7);
        check("simul up_level_a", up_level_a, 1'b1);
        check("simul down_level_a", down_level_a, 1'b1);
        tick(5);
        up_a = 1'b0;
        down_a = 1'b0;
        tick(10);

        // auto-repeat
        n = cyc;
        up_b = 1'b1;
        q[2].push_back(n + 5);
        for (int t = n + 15; t < n + 35; t += 3) q[2].push_back(t);
        tick(30);
        up_b = 1'b0;
        tick(10);

        // mutual exclusion while repeating
        n = cyc;
        up_b = 1'b1;
        q[2].push_back(n + 5);
        for (int t = n + 15; t < n + 55; t += 3)
            if (!(t >= n + 25 && t < n + 35)) q[2].push_back(t);
        tick(20);
        down_b = 1'b1;
        tick(5);
        check("mutex down_level_b", down_level_b, 1'b1);
        check("mutex up_level_b", up_level_b, 1'b1);
        tick(5);
        down_b = 1'b0;
        tick(20);
        up_b = 1'b0;
        tick(10);

        // reset during HOLD_REPEAT
        n = cyc;
        up_b = 1'b1;
        q[2].push_back(n + 5);
        q[2].push_back(n + 15);
        q[2].push_back(n + 18);
        q[2].push_back(n + 25);
        for (int t = n + 35; t < n + 45; t += 3) q[2].push_back(t);
        tick(19);
        rst_b = 1'b0;
        tick(1);
        check("mid-reset plus_b", plus_b, 1'b0);
        check("mid-reset up_level_b", up_level_b, 1'b0);
        rst_b = 1'b1;
        tick(20);
        up_b = 1'b0;
        tick(10);

        done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (q[c].size() != 0) begin
                errs++;
                $display("FAIL %s leftover: %0d pulses pending, required 0", names[c], q[c].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
